// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//   Shared definitions for the perceptron layer blocks.
//   - state_t     : sequencing FSM states for perceptron_mac (exposed on a debug port).
//   - DEF_*       : default widths / vector length.
//   - narrow_sat(): clamp a signed value (up to 64 bits) into a w-bit signed range.
//                   Callers keep the low w bits of the return value; o_ovf flags clamping.
//   Optional feature macro used by the blocks importing this package: PERCEPTRON_MAC_SAT_EN.
package perceptron_pkg;

  localparam int DEF_A_W    = 24;
  localparam int DEF_B_W    = 16;
  localparam int DEF_B_FRAC = 12;
  localparam int DEF_LEN    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp v to [-2^(w-1), 2^(w-1)-1]. w is expected to be a constant at the
  // call site, so hi/lo fold to constants in synthesis.
  function automatic logic signed [63:0] narrow_sat(input logic signed [63:0] v,
                                                    input int w,
                                                    output logic o_ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    o_ovf = 1'b0;
    if (v > hi) begin
      o_ovf = 1'b1;
      return hi;
    end else if (v < lo) begin
      o_ovf = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/perceptron_mac_if.sv
// perceptron_mac_if
//   Operand stream (sequencer -> MAC) and result stream (MAC -> writeback).
//   Handshake rule for both streams: a transfer happens on a posedge where
//   valid && ready; the source holds valid and its payload stable until that
//   edge, and ready never depends combinationally on valid.
//   master : operand source / result sink (sequencer + writeback side)
//   slave  : the MAC
//   Payload: a0/a1 activation candidates, b weight, x0/x1 bias candidates and
//   mode (bias/mode sampled on the first beat only); out / out_sat result.
interface perceptron_mac_if #(
  parameter int A_W = 24,
  parameter int B_W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a0;
  logic [A_W-1:0] a1;
  logic [B_W-1:0] b;
  logic [A_W-1:0] x0;
  logic [A_W-1:0] x1;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] out;
  logic           out_sat;

  modport master (
    output in_valid, a0, a1, b, x0, x1, mode, out_ready,
    input  in_ready, out_valid, out, out_sat
  );

  modport slave (
    input  in_valid, a0, a1, b, x0, x1, mode, out_ready,
    output in_ready, out_valid, out, out_sat
  );
endinterface

// File: rtl/perceptron_mac_mul.sv
// perceptron_mac_mul
//   Registered stage 1: p = narrow((a * b) >>> B_FRAC), full A_W+B_W product.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     i_en            a beat is accepted this cycle
//     i_first         the accepted beat is the first of its vector
//     i_a, i_b        selected activation, weight (signed)
//     o_valid         registered product valid (one cycle per accepted beat)
//     o_first         registered product belongs to the first beat
//     o_p             registered narrowed product
//     o_sat           narrowing clamped (only with PERCEPTRON_MAC_SAT_EN)
//   PERCEPTRON_MAC_SAT_EN: clamp on narrowing; otherwise two's-complement wrap.
module perceptron_mac_mul
  import perceptron_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int B_FRAC = DEF_B_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic           i_first,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_valid,
  output logic           o_first,
`ifdef PERCEPTRON_MAC_SAT_EN
  output logic           o_sat,
`endif
  output logic [A_W-1:0] o_p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] w_prod;
  logic [A_W-1:0]        w_p;

  assign w_prod = P_W'($signed(i_a)) * P_W'($signed(i_b));

`ifdef PERCEPTRON_MAC_SAT_EN
  logic w_sat;
  always_comb begin
    w_sat = 1'b0;
    w_p   = A_W'(narrow_sat(64'(w_prod >>> B_FRAC), A_W, w_sat));
  end
`else
  assign w_p = A_W'(w_prod >>> B_FRAC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_p     <= '0;
`ifdef PERCEPTRON_MAC_SAT_EN
      o_sat   <= 1'b0;
`endif
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        o_first <= i_first;
        o_p     <= w_p;
`ifdef PERCEPTRON_MAC_SAT_EN
        o_sat   <= w_sat;
`endif
      end
    end
  end

endmodule

// File: rtl/perceptron_mac.sv
// perceptron_mac
//   Sequential fixed-point MAC: out = x + sum(a[i]*b[i]) over LEN beats.
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     bus           perceptron_mac_if.slave (operand stream in, result stream out)
//     o_dbg_state   current FSM state
//   Pipeline: beat accepted -> product registered (stage 1) -> accumulated
//   (stage 2). FLUSH is the one cycle that lets the last product land in the
//   accumulator before DONE presents it.
//   PERCEPTRON_MAC_SAT_EN: saturating products/sums and sticky out_sat;
//   otherwise wraparound and out_sat tied low.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int B_FRAC = DEF_B_FRAC,
  parameter int LEN    = DEF_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  perceptron_mac_if.slave       bus,
  output state_t                o_dbg_state
);

  localparam int CNT_W = (LEN < 2) ? 1 : $clog2(LEN + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [A_W-1:0]   r_x;
  logic [A_W-1:0]   r_acc;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first_beat;
  logic             w_mode_sel;
  logic [A_W-1:0]   w_a;

  logic             w_p_valid;
  logic             w_p_first;
  logic [A_W-1:0]   w_p;
  logic [A_W-1:0]   w_base;
  logic [A_W-1:0]   w_acc_next;

  assign w_in_ready   = (r_state == IDLE) || (r_state == ACC);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_first_beat = (r_state == IDLE);
  // The first beat uses the live mode; later beats use the latched one.
  assign w_mode_sel   = w_first_beat ? bus.mode : r_mode;
  assign w_a          = w_mode_sel ? bus.a1 : bus.a0;

  // FSM and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode  <= bus.mode;
            r_x     <= bus.mode ? bus.x1 : bus.x0;
            r_cnt   <= CNT_W'(1);
            r_state <= (LEN == 1) ? FLUSH : ACC;
          end
        end
        ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LEN - 1)) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  perceptron_mac_mul #(
    .A_W    (A_W),
    .B_W    (B_W),
    .B_FRAC (B_FRAC)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept),
    .i_first (w_first_beat),
    .i_a     (w_a),
    .i_b     (bus.b),
    .o_valid (w_p_valid),
    .o_first (w_p_first),
`ifdef PERCEPTRON_MAC_SAT_EN
    .o_sat   (w_p_sat),
`endif
    .o_p     (w_p)
  );

  // Stage 2: the first product of a vector starts from the latched bias.
  assign w_base = w_p_first ? r_x : r_acc;

`ifdef PERCEPTRON_MAC_SAT_EN
  logic w_p_sat;
  logic w_sum_ovf;
  logic r_sat;

  // Sign-extended 64-bit add is exact for the A_W+1-bit sum.
  always_comb begin
    w_sum_ovf  = 1'b0;
    w_acc_next = A_W'(narrow_sat(64'($signed(w_base)) + 64'($signed(w_p)), A_W, w_sum_ovf));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_accept && w_first_beat) begin
      r_sat <= 1'b0;
    end else if (w_p_valid) begin
      r_sat <= r_sat | w_p_sat | w_sum_ovf;
    end
  end

  assign bus.out_sat = r_sat;
`else
  assign w_acc_next  = w_base + w_p;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_p_valid) begin
      r_acc <= w_acc_next;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_acc;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_perceptron_mac.sv
// tb_perceptron_mac
//   Bench for perceptron_mac (LEN=4, B_FRAC=12). Honours PERCEPTRON_MAC_SAT_EN
//   for the expected overflow behaviour.
module tb_perceptron_mac;
  import perceptron_pkg::*;

  localparam int A_W    = 24;
  localparam int B_W    = 16;
  localparam int B_FRAC = 12;
  localparam int LEN    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  perceptron_mac_if #(.A_W(A_W), .B_W(B_W)) bus ();
  state_t dbg_state;

  perceptron_mac #(
    .A_W    (A_W),
    .B_W    (B_W),
    .B_FRAC (B_FRAC),
    .LEN    (LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [A_W-1:0] exp_q[$];
  logic           exp_sat_q[$];

  logic [A_W-1:0] va0[LEN];
  logic [A_W-1:0] va1[LEN];
  logic [B_W-1:0] vb[LEN];
  int             first_tries;
  logic           rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [A_W-1:0] v, input logic s);
    exp_q.push_back(v);
    exp_sat_q.push_back(s);
  endtask

  // Reference: plain integer arithmetic on the vector.
  function automatic logic [A_W-1:0] ref_narrow(input longint v, output logic s);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (A_W - 1)) - 1;
    lo = -hi - 1;
    s  = 1'b0;
`ifdef PERCEPTRON_MAC_SAT_EN
    if (v > hi) begin s = 1'b1; v = hi; end
    else if (v < lo) begin s = 1'b1; v = lo; end
`endif
    return v[A_W-1:0];
  endfunction

  task automatic push_model(input logic md, input logic [A_W-1:0] xv0, input logic [A_W-1:0] xv1);
    longint         acc;
    longint         p;
    logic [A_W-1:0] pn;
    logic [A_W-1:0] an;
    logic           s;
    logic           sat;
    sat = 1'b0;
    acc = longint'($signed(md ? xv1 : xv0));
    an  = '0;
    for (int i = 0; i < LEN; i++) begin
      p   = (longint'($signed(md ? va1[i] : va0[i])) * longint'($signed(vb[i]))) >>> B_FRAC;
      pn  = ref_narrow(p, s);
      sat = sat | s;
      an  = ref_narrow(acc + longint'($signed(pn)), s);
      sat = sat | s;
      acc = longint'($signed(an));
    end
    push_exp(an, sat);
  endtask

  task automatic fill(input int i, input int a0v, input int a1v, input int bv);
    va0[i] = A_W'(a0v);
    va1[i] = A_W'(a1v);
    vb[i]  = B_W'(bv);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic md, input logic [A_W-1:0] a0v, input logic [A_W-1:0] a1v,
                           input logic [B_W-1:0] bv, input logic [A_W-1:0] x0v,
                           input logic [A_W-1:0] x1v, output int tries);
    logic accepted;
    bus.in_valid = 1'b1;
    bus.mode = md; bus.a0 = a0v; bus.a1 = a1v; bus.b = bv; bus.x0 = x0v; bus.x1 = x1v;
    tries = 0;
    accepted = 1'b0;
    while (!accepted && tries < 100) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    check("beat_accept", accepted, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic md, input logic [A_W-1:0] xv0, input logic [A_W-1:0] xv1,
                          input int gap, input logic scramble);
    int   tries;
    logic m;
    logic [A_W-1:0] x0v;
    logic [A_W-1:0] x1v;
    for (int i = 0; i < LEN; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      m   = md;
      x0v = xv0;
      x1v = xv1;
      if (i > 0 && scramble) begin
        m   = 1'($urandom_range(0, 1));
        x0v = A_W'($urandom);
        x1v = A_W'($urandom);
      end
      send_beat(m, va0[i], va1[i], vb[i], x0v, x1v, tries);
      if (i == 0) first_tries = tries;
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 0);
  endtask

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- output monitor ----------------
  logic           held = 1'b0;
  logic [A_W-1:0] held_out;
  logic           held_sat;
  logic           fall_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held     = 1'b0;
      fall_chk = 1'b0;
    end else begin
      if (fall_chk) begin
        check("ov_fall", bus.out_valid, 0);
        fall_chk = 1'b0;
      end
      if (bus.out_valid) begin
        check("in_rdy_done", bus.in_ready, 0);
        if (held) begin
          check("hold_out", bus.out, held_out);
          check("hold_sat", bus.out_sat, held_sat);
        end
        if (bus.out_ready) begin
          check("exp_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("out", bus.out, exp_q.pop_front());
            check("out_sat", bus.out_sat, exp_sat_q.pop_front());
          end
          held     = 1'b0;
          fall_chk = 1'b1;
        end else begin
          held     = 1'b1;
          held_out = bus.out;
          held_sat = bus.out_sat;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b = '0; bus.x0 = '0; bus.x1 = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // basic mode 0 with latency check
    for (int i = 0; i < LEN; i++) fill(i, 10 * (i + 1), 0, 4096);
    push_exp(A_W'(200), 1'b0);
    send_vec(1'b0, A_W'(100), A_W'(777), 0, 1'b0);
    @(negedge clk);
    check("lat_t1", bus.out_valid, 0);
    @(negedge clk);
    check("lat_t2", bus.out_valid, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain();

    // back-to-back vectors: next first beat lands at t+3
    for (int i = 0; i < LEN; i++) fill(i, 1, 0, 4096);
    push_exp(A_W'(5), 1'b0);
    send_vec(1'b0, A_W'(1), A_W'(0), 0, 1'b0);
    for (int i = 0; i < LEN; i++) fill(i, 2, 0, 4096);
    push_exp(A_W'(10), 1'b0);
    send_vec(1'b0, A_W'(2), A_W'(0), 0, 1'b0);
    check("t3_accept", 64'(first_tries), 3);
    wait_drain();

    // mode latch: later mode/x changes ignored
    for (int i = 0; i < LEN; i++) fill(i, 999, i + 1, 4096);
    push_exp(A_W'(0), 1'b0);
    send_vec(1'b1, A_W'(555), A_W'(-10), 0, 1'b1);
    wait_drain();

    // fraction and sign
    for (int i = 0; i < LEN; i++) fill(i, 0, 0, 4096);
    fill(0, -3000, 0, -2048);
    push_exp(A_W'(1500), 1'b0);
    send_vec(1'b0, A_W'(0), A_W'(0), 0, 1'b0);
    fill(0, 1, 0, -1);
    push_exp(A_W'(-1), 1'b0);
    send_vec(1'b0, A_W'(0), A_W'(0), 0, 1'b0);
    wait_drain();

    // gaps on input, backpressure on output
    bus.out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) fill(i, i + 1, 0, 4096);
    push_exp(A_W'(15), 1'b0);
    send_vec(1'b0, A_W'(5), A_W'(0), 3, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    check("bp_valid", bus.out_valid, 1);
    repeat (5) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    wait_drain();

    // overflow, then a clean vector (sat must clear)
    for (int i = 0; i < LEN; i++) fill(i, 0, 0, 4096);
    fill(0, 'h100, 0, 4096);
`ifdef PERCEPTRON_MAC_SAT_EN
    push_exp(A_W'('h7FFFFF), 1'b1);
`else
    push_exp(A_W'('h8000F0), 1'b0);
`endif
    send_vec(1'b0, A_W'('h7FFFF0), A_W'(0), 0, 1'b0);
    for (int i = 0; i < LEN; i++) fill(i, 10 * (i + 1), 0, 4096);
    push_exp(A_W'(200), 1'b0);
    send_vec(1'b0, A_W'(100), A_W'(0), 0, 1'b0);
    wait_drain();

    // reset mid-vector
    send_beat(1'b0, A_W'(5000), A_W'(0), B_W'(4096), A_W'(3333), A_W'(0), t);
    send_beat(1'b0, A_W'(5000), A_W'(0), B_W'(4096), A_W'(0), A_W'(0), t);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_state", dbg_state, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < LEN; i++) fill(i, 10 * (i + 1), 0, 4096);
    push_exp(A_W'(200), 1'b0);
    send_vec(1'b0, A_W'(100), A_W'(0), 0, 1'b0);
    wait_drain();

    // randomized vectors against the reference
    rnd_ready = 1'b1;
    for (int v = 0; v < 24; v++) begin
      logic md;
      logic [A_W-1:0] xv0;
      logic [A_W-1:0] xv1;
      md  = 1'($urandom_range(0, 1));
      xv0 = A_W'($urandom);
      xv1 = A_W'($urandom);
      for (int i = 0; i < LEN; i++) begin
        if (v % 2 == 0) begin
          va0[i] = A_W'($urandom);
          va1[i] = A_W'($urandom);
          vb[i]  = B_W'($urandom);
        end else begin
          va0[i] = A_W'($urandom_range(0, 20000)) - A_W'(10000);
          va1[i] = A_W'($urandom_range(0, 20000)) - A_W'(10000);
          vb[i]  = B_W'($urandom_range(0, 16384)) - B_W'(8192);
        end
      end
      push_model(md, xv0, xv1);
      send_vec(md, xv0, xv1, $urandom_range(0, 2), 1'b1);
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2 bus.out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
